// File: rtl/dht11_sample_manager_pkg.sv
// Shared types for the DHT11 sample manager: frame layout,
// FSM states and sanity limits.
package dht11_sample_manager_pkg;

  localparam int FRAME_W = 40;
  localparam logic [7:0] RH_MAX = 8'd100;

  typedef enum logic [2:0] {
    IDLE,
    REQ,
    WAIT,
    CHECK,
    UPDATE,
    HOLD
  } state_t;

  typedef struct packed {
    logic [7:0] rh_int;
    logic [7:0] rh_dec;
    logic [7:0] t_int;
    logic [7:0] t_dec;
    logic [7:0] sum;
  } frame_t;

endpackage

// File: rtl/dht11_ms_tick.sv
// Millisecond strobe generator; clr makes the current cycle count 0,
// so a period measured from the clr cycle is exact.
module dht11_ms_tick #(
  parameter int CLK_HZ = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int DIV = CLK_HZ / 1000;
  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_eff;

  assign cnt_eff = clr ? '0 : cnt;
  assign tick    = (cnt_eff == LAST);

  always_ff @(posedge clk) begin
    if (rst) cnt <= '0;
    else     cnt <= tick ? '0 : cnt_eff + 1'b1;
  end

endmodule

// File: rtl/dht11_sample_manager.sv
// Paces the DHT11 receiver, validates each frame and publishes
// humidity/temperature on a valid/ready port with health status.
module dht11_sample_manager
  import dht11_sample_manager_pkg::*;
#(
  parameter int CLK_HZ      = 100_000,
  parameter int POLL_MS     = 2000,
  parameter int TIMEOUT_MS  = 50,
  parameter int STALE_POLLS = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [FRAME_W-1:0] frame_data,
  input  logic               frame_valid,
  output logic               req_start,
  output logic [7:0]         hum_int,
  output logic [7:0]         hum_dec,
  output logic [7:0]         temp_int,
  output logic [7:0]         temp_dec,
  output logic               sample_valid,
  input  logic               sample_ready,
  output logic               overrun,
  output logic               crc_err,
  output logic [7:0]         err_count,
  output logic [7:0]         timeout_count,
  output logic               stale
);

  localparam logic [15:0] POLL_LAST = 16'(POLL_MS - 1);
  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT_MS - 1);
  localparam logic [7:0]  STALE_N   = 8'(STALE_POLLS);

  function automatic logic frame_good(input frame_t f);
    logic [7:0] s;
    s = f.rh_int + f.rh_dec + f.t_int + f.t_dec;
    return (s == f.sum) && (f != '0) && (f.rh_int <= RH_MAX);
  endfunction

  state_t      state, state_nx;
  frame_t      frame_q;
  logic        tick, clr;
  logic [15:0] poll_cnt;
  logic [7:0]  fail_cnt, fail_inc;
  logic        good, timeout_hit, poll_hit, accept;

  dht11_ms_tick #(.CLK_HZ(CLK_HZ)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .tick (tick)
  );

  assign good        = frame_good(frame_q);
  assign accept      = sample_valid && sample_ready;
  assign fail_inc    = (fail_cnt >= STALE_N) ? fail_cnt : fail_cnt + 8'd1;
  assign timeout_hit = (tick && poll_cnt == TO_LAST) || poll_cnt > TO_LAST;
  assign poll_hit    = (tick && poll_cnt == POLL_LAST) || poll_cnt > POLL_LAST;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    clr       = 1'b0;
    req_start = 1'b0;
    unique case (state)
      IDLE:   state_nx = REQ;
      REQ: begin
        req_start = 1'b1;
        clr       = 1'b1;
        state_nx  = WAIT;
      end
      WAIT: begin
        if (frame_valid)      state_nx = CHECK;
        else if (timeout_hit) state_nx = HOLD;
      end
      CHECK:  state_nx = good ? UPDATE : HOLD;
      UPDATE: state_nx = HOLD;
      HOLD:   if (poll_hit) state_nx = REQ;
      default: state_nx = IDLE;
    endcase
  end

  // Poll timer counts ms since the REQ pulse; shared by timeout and pacing
  always_ff @(posedge clk) begin
    if (rst || state == REQ)        poll_cnt <= '0;
    else if (tick && poll_cnt != '1) poll_cnt <= poll_cnt + 16'd1;
  end

  // Good frames are loaded at the end of CHECK so data appears two
  // cycles after frame_valid; UPDATE is the cycle they first show.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q       <= '0;
      hum_int       <= '0;
      hum_dec       <= '0;
      temp_int      <= '0;
      temp_dec      <= '0;
      sample_valid  <= 1'b0;
      overrun       <= 1'b0;
      crc_err       <= 1'b0;
      err_count     <= '0;
      timeout_count <= '0;
      fail_cnt      <= '0;
      stale         <= 1'b0;
    end else begin
      crc_err <= 1'b0;
      if (state == WAIT && frame_valid) frame_q <= frame_data;
      if (state == WAIT && !frame_valid && timeout_hit) begin
        if (timeout_count != 8'hff) timeout_count <= timeout_count + 8'd1;
        fail_cnt <= fail_inc;
        stale    <= (fail_inc >= STALE_N);
      end
      if (state == CHECK && good) begin
        hum_int      <= frame_q.rh_int;
        hum_dec      <= frame_q.rh_dec;
        temp_int     <= frame_q.t_int;
        temp_dec     <= frame_q.t_dec;
        sample_valid <= 1'b1;
        fail_cnt     <= '0;
        stale        <= 1'b0;
        if (sample_valid && !sample_ready) overrun <= 1'b1;
      end else begin
        if (accept) sample_valid <= 1'b0;
        if (state == CHECK) begin
          crc_err  <= 1'b1;
          fail_cnt <= fail_inc;
          stale    <= (fail_inc >= STALE_N);
          if (err_count != 8'hff) err_count <= err_count + 8'd1;
        end
      end
    end
  end

endmodule
